// File: rtl/xdispctrl_pkg.sv
// Package for xdispctrl: scan FSM state encodings and the anode helper.
// No ports.
package xdispctrl_pkg;

   localparam int NUM_DIGITS = 4;

   // Scan FSM encodings
   localparam logic [0:0] ST_SHOW = 1'b0;
   localparam logic [0:0] ST_GAP  = 1'b1;

   // Active-low anode select for digit idx
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/xdefs.vh
// Shared definitions for the xdispctrl peripheral: bus data width, register
// map, CTRL bit positions and the all-segments-off pattern.
`ifndef XDEFS_VH
`define XDEFS_VH

`ifndef DATA_W
`define DATA_W 32
`endif

// Register map
`define XDISP_ADDR_D0   3'd0
`define XDISP_ADDR_D3   3'd3
`define XDISP_ADDR_CTRL 3'd4

// CTRL bit positions
`define XDISP_CTRL_EN   0
`define XDISP_CTRL_GAP  1

// Segment pattern with every segment and dp dark (active-low drive)
`define XDISP_BLANK     8'hFF

`endif

// File: rtl/xseg7dec.sv
// Hex digit to seven-segment decoder (combinational).
// Ports:
//   hex_i  - 4-bit hex value
//   seg_o  - active-high segments {g,f,e,d,c,b,a}
module xseg7dec (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h00;
      case (hex_i)
         4'h0: seg_o = 7'h3F;
         4'h1: seg_o = 7'h06;
         4'h2: seg_o = 7'h5B;
         4'h3: seg_o = 7'h4F;
         4'h4: seg_o = 7'h66;
         4'h5: seg_o = 7'h6D;
         4'h6: seg_o = 7'h7D;
         4'h7: seg_o = 7'h07;
         4'h8: seg_o = 7'h7F;
         4'h9: seg_o = 7'h6F;
         4'hA: seg_o = 7'h77;
         4'hB: seg_o = 7'h7C;
         4'hC: seg_o = 7'h39;
         4'hD: seg_o = 7'h5E;
         4'hE: seg_o = 7'h79;
         default: seg_o = 7'h71;
      endcase
   end

endmodule

// File: rtl/xdispctrl.sv
// Four-digit multiplexed seven-segment display controller on the picoVersat
// peripheral bus.
// Parameters:
//   DIV_W     - refresh prescaler width; each digit is held 2**DIV_W clocks
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   sel, we   - bus select / write enable
//   addr      - register address (0-3 digits, 4 CTRL, 5-7 reserved)
//   data_in   - write data, bits [7:0] used
//   data_out  - registered read data, zero-extended
//   Disp      - segments, active-low {dp,g..a}
//   Disp_sel  - digit anodes, active-low
// Build option DISP_DECODE_EN: digit registers hold a hex nibble plus dp
// (bit 4) and are decoded through xseg7dec; otherwise digit registers hold
// raw active-high segments.
`include "xdefs.vh"

module xdispctrl
   import xdispctrl_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              we,
   input  logic [2:0]        addr,
   input  logic [`DATA_W-1:0] data_in,
   output logic [`DATA_W-1:0] data_out,
   output logic [7:0]        Disp,
   output logic [3:0]        Disp_sel
);

   logic [NUM_DIGITS-1:0][7:0] dig_q, dig_d;
   logic [1:0]                 ctrl_q, ctrl_d;
   logic [DIV_W-1:0]           presc_q, presc_d;
   logic [1:0]                 idx_q, idx_d;
   logic [0:0]                 state_q, state_d;
   logic [`DATA_W-1:0]         rdata_q, rdata_d;
   logic [7:0]                 disp_q, disp_d;
   logic [3:0]                 dsel_q, dsel_d;

   logic       wr, rd, en, gap_en, tc;
   logic [7:0] cur, pattern;

   assign wr     = sel & we;
   assign rd     = sel & ~we;
   assign en     = ctrl_q[`XDISP_CTRL_EN];
   assign gap_en = ctrl_q[`XDISP_CTRL_GAP];
   assign tc     = (presc_q == '1);
   assign cur    = dig_q[idx_q];

`ifdef DISP_DECODE_EN
   logic [6:0] seg;
   logic       unused_dec;

   xseg7dec u_dec (
      .hex_i (cur[3:0]),
      .seg_o (seg)
   );

   // dp sits in bit 4 of the digit register, segments come from the nibble
   assign pattern    = {cur[4], seg};
   assign unused_dec = ^cur[7:5];
`else
   assign pattern = cur;
`endif

   logic unused_bits;
   assign unused_bits = ^data_in[`DATA_W-1:8];

   // Register writes
   always_comb begin
      dig_d  = dig_q;
      ctrl_d = ctrl_q;
      if (wr) begin
         if (addr <= `XDISP_ADDR_D3) begin
            dig_d[addr[1:0]] = data_in[7:0];
         end else if (addr == `XDISP_ADDR_CTRL) begin
            ctrl_d[`XDISP_CTRL_EN]  = data_in[`XDISP_CTRL_EN];
            ctrl_d[`XDISP_CTRL_GAP] = data_in[`XDISP_CTRL_GAP];
         end
      end
   end

   // Register reads: captured from the pre-write register contents
   always_comb begin
      rdata_d = rdata_q;
      if (rd) begin
         rdata_d = '0;
         if (addr <= `XDISP_ADDR_D3) begin
            rdata_d[7:0] = dig_q[addr[1:0]];
         end else if (addr == `XDISP_ADDR_CTRL) begin
            rdata_d[1:0] = ctrl_q;
         end
      end
   end

   // Scan sequencer. The prescaler is frozen during GAP so each digit still
   // gets a full 2**DIV_W clocks of on-time after the dead cycle.
   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      state_d = state_q;
      if (!en) begin
         presc_d = '0;
         state_d = ST_SHOW;
      end else begin
         case (state_q)
            ST_SHOW: begin
               presc_d = presc_q + 1'b1;
               if (tc) begin
                  idx_d = idx_q + 2'd1;
                  if (gap_en) state_d = ST_GAP;
               end
            end
            default: state_d = ST_SHOW;
         endcase
      end
   end

   // Output stage: one register behind the scan state, built from the
   // current digit registers so a write is never shown stale.
   always_comb begin
      disp_d = `XDISP_BLANK;
      dsel_d = 4'hF;
      if (en && state_q == ST_SHOW) begin
         disp_d = ~pattern;
         dsel_d = anode_sel(idx_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dig_q   <= '0;
         ctrl_q  <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         state_q <= ST_SHOW;
         rdata_q <= '0;
         disp_q  <= `XDISP_BLANK;
         dsel_q  <= 4'hF;
      end else begin
         dig_q   <= dig_d;
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         rdata_q <= rdata_d;
         disp_q  <= disp_d;
         dsel_q  <= dsel_d;
      end
   end

   assign data_out = rdata_q;
   assign Disp     = disp_q;
   assign Disp_sel = dsel_q;

endmodule

// File: tb/tb_xdispctrl.sv
// Scoreboard bench for xdispctrl with DIV_W=2. Stimulus pushes expected
// (cycle, output, value) entries; a negedge monitor compares and retires them.
`timescale 1ns/1ps
`include "xdefs.vh"

module tb_xdispctrl;

   localparam int DW = `DATA_W;

   // Expected segment drive for the digit values used below
`ifdef DISP_DECODE_EN
   localparam logic [7:0] E0 = 8'hF9;   // D0=8'h81 -> '1'
   localparam logic [7:0] E1 = 8'hA4;   // '2'
   localparam logic [7:0] E2 = 8'hB0;   // '3'
   localparam logic [7:0] E3 = 8'h99;   // '4'
   localparam logic [7:0] ELIVE = 8'h80; // '8'
   localparam logic [7:0] EDP = 8'h00;   // '8' with dp
`else
   localparam logic [7:0] E0 = 8'h7E;
   localparam logic [7:0] E1 = 8'hFD;
   localparam logic [7:0] E2 = 8'hFC;
   localparam logic [7:0] E3 = 8'hFB;
   localparam logic [7:0] ELIVE = 8'hF7;
   localparam logic [7:0] EDP = 8'hE7;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sel = 1'b0;
   logic          we = 1'b0;
   logic [2:0]    addr = 3'd0;
   logic [DW-1:0] data_in = '0;
   wire  [DW-1:0] data_out;
   wire  [7:0]    Disp;
   wire  [3:0]    Disp_sel;

   xdispctrl #(.DIV_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .we       (we),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .Disp     (Disp),
      .Disp_sel (Disp_sel)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          kind;   // 0 Disp, 1 Disp_sel, 2 data_out
      logic [31:0] val;
      int          tag;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   function automatic string kname(input int k);
      if (k == 0) return "disp";
      if (k == 1) return "disp_sel";
      return "data_out";
   endfunction

   function automatic logic [7:0] edig(input int k);
      case (k % 4)
         0: return E0;
         1: return E1;
         2: return E2;
         default: return E3;
      endcase
   endfunction

   function automatic logic [3:0] eanode(input int k);
      case (k % 4)
         0: return 4'hE;
         1: return 4'hD;
         2: return 4'hB;
         default: return 4'h7;
      endcase
   endfunction

   task automatic expect_at(input int c, input int k, input logic [31:0] v, input int tag);
      exp_t e;
      e.cyc = c; e.kind = k; e.val = v; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic expect_show(input int c, input logic [7:0] d, input logic [3:0] a, input int tag);
      expect_at(c, 0, {24'b0, d}, tag);
      expect_at(c, 1, {28'b0, a}, tag);
   endtask

   task automatic expect_blank(input int c, input int tag);
      expect_show(c, 8'hFF, 4'hF, tag);
   endtask

   // Monitor: retire every entry due this cycle
   always @(negedge clk) begin : mon
      logic [31:0] act;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s tag=%0d missed at cycle %0d", kname(q[i].kind), q[i].tag, q[i].cyc);
            q.delete(i);
         end else if (q[i].cyc == cyc) begin
            case (q[i].kind)
               0:       act = {24'b0, Disp};
               1:       act = {28'b0, Disp_sel};
               default: act = 32'(data_out);
            endcase
            checks++;
            if (act !== q[i].val) begin
               failures++;
               $display("FAIL %s tag=%0d cycle=%0d got=%h expected=%h",
                        kname(q[i].kind), q[i].tag, cyc, act, q[i].val);
            end
            q.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   // Returns the cycle whose edge sampled the write
   task automatic wr(input logic [2:0] a, input logic [7:0] d, output int c);
      sel = 1'b1; we = 1'b1; addr = a; data_in = DW'(d);
      tick();
      c = cyc;
      sel = 1'b0; we = 1'b0; data_in = '0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] v, input int tag);
      sel = 1'b1; we = 1'b0; addr = a;
      expect_at(cyc + 1, 2, v, tag);
      tick();
      sel = 1'b0;
   endtask

   // Reset, optionally racing a write of D0 that must lose
   task automatic do_reset(input bit with_write, input int tag);
      rst = 1'b1;
      if (with_write) begin
         sel = 1'b1; we = 1'b1; addr = 3'd0; data_in = DW'(8'h55);
      end
      expect_blank(cyc + 1, tag);
      tick();
      rst = 1'b0; sel = 1'b0; we = 1'b0; data_in = '0;
   endtask

   task automatic load_digits();
      int c;
      wr(3'd0, 8'h81, c);
      wr(3'd1, 8'h02, c);
      wr(3'd2, 8'h03, c);
      wr(3'd3, 8'h04, c);
   endtask

   initial begin
      int w, l, x, y, c;

      // Reset state, reset beats concurrent write
      tick();
      do_reset(1'b1, 100);
      for (int a = 0; a < 5; a++) rd(3'(a), 32'h0, 110 + a);

      // Plain scan, no gap
      load_digits();
      wr(3'd4, 8'h01, w);
      expect_blank(w, 200);
      for (int s = 0; s < 5; s++)
         for (int j = 0; j < 4; j++)
            expect_show(w + 1 + 4 * s + j, edig(s), eanode(s), 210 + s);
      wait_until(w + 21);
      rd(3'd0, 32'h81, 220);
      rd(3'd2, 32'h03, 221);
      rd(3'd4, 32'h01, 222);

      // Live write to the active digit, and write landing on an advance
      do_reset(1'b0, 300);
      load_digits();
      wr(3'd4, 8'h01, w);
      expect_show(w + 4, E0, 4'hE, 310);
      expect_show(w + 5, E1, 4'hD, 311);
      wait_until(w + 5);
      wr(3'd1, 8'h08, l);
      expect_show(l, E1, 4'hD, 312);
      expect_show(l + 1, ELIVE, 4'hD, 313);
      expect_show(l + 2, ELIVE, 4'hD, 314);
      wait_until(w + 7);
      wr(3'd2, 8'h18, c);
      for (int j = 1; j <= 4; j++) expect_show(c + j, EDP, 4'hB, 320 + j);
      expect_show(c + 5, E3, 4'h7, 325);
      wait_until(c + 6);

      // Dead cycle between digits
      do_reset(1'b0, 400);
      load_digits();
      wr(3'd4, 8'h03, w);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) expect_blank(w + 5 * k, 410 + k);
         for (int j = 0; j < 4; j++)
            expect_show(w + 1 + 5 * k + j, edig(k), eanode(k), 420 + k);
      end
      wait_until(w + 31);

      // Disable mid digit 2, then resume
      do_reset(1'b0, 500);
      load_digits();
      wr(3'd4, 8'h01, w);
      wait_until(w + 8);
      wr(3'd4, 8'h00, x);
      expect_show(x, E2, 4'hB, 510);
      for (int j = 1; j <= 3; j++) expect_blank(x + j, 511);
      wait_until(x + 3);
      wr(3'd4, 8'h01, y);
      expect_blank(y, 520);
      for (int j = 1; j <= 4; j++) expect_show(y + j, E2, 4'hB, 521);
      for (int j = 5; j <= 8; j++) expect_show(y + j, E3, 4'h7, 522);
      expect_show(y + 9, E0, 4'hE, 523);
      wait_until(y + 10);

      // Reserved address write, read-back, data_out hold, CTRL mask
      wr(3'd6, 8'hFF, c);
      rd(3'd0, 32'h81, 600);
      expect_at(cyc + 1, 2, 32'h81, 601);
      expect_at(cyc + 2, 2, 32'h81, 602);
      tick(); tick();
      rd(3'd1, 32'h02, 603);
      rd(3'd2, 32'h03, 604);
      rd(3'd3, 32'h04, 605);
      rd(3'd4, 32'h01, 606);
      rd(3'd5, 32'h00, 607);
      rd(3'd6, 32'h00, 608);
      rd(3'd7, 32'h00, 609);
      wr(3'd4, 8'hFF, c);
      rd(3'd4, 32'h03, 610);

      for (int i = 0; i < 50 && q.size() > 0; i++) tick();
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
